// File: rtl/fixed_point_pkg.sv
// Shared op codes, FSM states and fixed-point helpers for the expression-evaluator ALU.
// Pure declarations: no latency, no flow control.
package fixed_point_pkg;

  localparam logic [2:0] PLUS = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] MUL  = 3'b010;
  localparam logic [2:0] DIV  = 3'b011;
  localparam logic [2:0] POW  = 3'b100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;

  // 1.0 in a format with frac_width fractional bits; callers size-cast to N.
  function automatic logic [63:0] fx_one(input int frac_width);
    return 64'd1 << frac_width;
  endfunction

endpackage

// File: rtl/fixed_point_divider.sv
// Sequential signed divider computing (a << F) / b, truncated toward zero, low N bits kept.
// Latency N+F edges from start to a one-cycle done pulse; start while busy is ignored.
module fixed_point_divider #(
  parameter int N = 16,
  parameter int F = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] quotient
);

  localparam int DW = N + F;
  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] dvd;
  logic [N-1:0]  rem;
  logic [N-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          neg;
  logic          a_neg;
  logic          div_zero;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic [N-1:0]  q_low;

  // Magnitudes fit in N unsigned bits, including the most negative value.
  assign a_mag   = a[N-1] ? -a : a;
  assign b_mag   = b[N-1] ? -b : b;
  assign shifted = {rem, dvd[DW-1]};
  assign trial   = shifted - {1'b0, dvs};
  assign q_low   = dvd[N-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      dvd      <= '0;
      rem      <= '0;
      dvs      <= '0;
      neg      <= 1'b0;
      a_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy     <= 1'b1;
        cnt      <= CW'(DW);
        dvd      <= {a_mag, {F{1'b0}}};
        rem      <= '0;
        dvs      <= b_mag;
        neg      <= a[N-1] ^ b[N-1];
        a_neg    <= a[N-1];
        div_zero <= (b == '0);
      end else if (busy) begin
        // Restoring step: quotient bits shift into the freed low end of dvd.
        if (trial[N]) begin
          rem <= shifted[N-1:0];
          dvd <= {dvd[DW-2:0], 1'b0};
        end else begin
          rem <= trial[N-1:0];
          dvd <= {dvd[DW-2:0], 1'b1};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    quotient = neg ? -q_low : q_low;
    if (div_zero) quotient = a_neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end

endmodule

// File: rtl/fixed_point_alu.sv
// Multi-cycle signed fixed-point ALU (add/sub/mul/div/pow) with start/done handshake.
// Latency 1 edge (DIV N+F+1, POW 1+e); start while busy is ignored, done holds until next start.
module fixed_point_alu
  import fixed_point_pkg::*;
#(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  localparam int N = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
  localparam int F = FRACTIONAL_PART_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         done,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result
);

  localparam logic [N-1:0] ONE = N'(fx_one(F));

  alu_state_t state, state_nxt;

  logic [2:0]                    op_q;
  logic [N-1:0]                  a_q;
  logic [N-1:0]                  b_q;
  logic [N-1:0]                  acc;
  logic [INTEGER_PART_WIDTH-1:0] exp_cnt;
  logic                          accept;
  logic                          fin;
  logic [N-1:0]                  fin_val;
  logic [N-1:0]                  mul_x;
  logic [N-1:0]                  mul_y;
  logic signed [N+F-1:0]         mul_prod;
  logic [N-1:0]                  mul_res;
  logic [F-1:0]                  mul_frac_unused;
  logic                          div_done;
  logic [N-1:0]                  div_q;

  assign accept = start && (state != BUSY);
  assign done   = (state == DONE);

  // Low N+F bits of the signed product; dropping the bottom F is an arithmetic shift.
  assign mul_prod = $signed({{F{mul_x[N-1]}}, mul_x}) * $signed({{F{mul_y[N-1]}}, mul_y});
  assign {mul_res, mul_frac_unused} = mul_prod;

  fixed_point_divider #(.N(N), .F(F)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && (op == DIV)),
    .a        (a),
    .b        (b),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    fin_val   = '0;
    mul_x     = a_q;
    mul_y     = b_q;
    case (state)
      IDLE, DONE: if (start) state_nxt = BUSY;
      BUSY: begin
        case (op_q)
          PLUS: begin fin = 1'b1; fin_val = a_q + b_q; end
          SUB:  begin fin = 1'b1; fin_val = a_q - b_q; end
          MUL:  begin fin = 1'b1; fin_val = mul_res;   end
          DIV:  begin fin = div_done; fin_val = div_q; end
          POW: begin
            mul_x = acc;
            mul_y = a_q;
            if (b_q[N-1])          begin fin = 1'b1; fin_val = '0;  end
            else if (exp_cnt == '0) begin fin = 1'b1; fin_val = acc; end
          end
          default: begin fin = 1'b1; fin_val = '0; end
        endcase
        if (fin) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      exp_cnt <= '0;
    end else if (accept) begin
      op_q    <= op;
      a_q     <= a;
      b_q     <= b;
      acc     <= ONE;
      exp_cnt <= b[N-1:F];
    end else if (state == BUSY) begin
      if (fin) begin
        result <= fin_val;
      end else if (op_q == POW) begin
        acc     <= mul_res;
        exp_cnt <= exp_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_alu.sv
// Self-checking bench for fixed_point_alu in Q8.8: directed table, handshake corners, random vs model.
// Expected values come from hand-derived constants and an integer-arithmetic reference model.
module tb_fixed_point_alu;

  localparam int LAT_DIV_MAX = 16 + 8 + 1;
  localparam int BOUND       = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        done;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    int          lat;   // 0 means "any latency up to the DIV maximum"
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  fixed_point_alu #(.INTEGER_PART_WIDTH(8), .FRACTIONAL_PART_WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .done   (done),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint r  = 0;
    longint p;
    longint e;
    logic [15:0] t;
    case (o)
      3'd0: r = sx + sy;
      3'd1: r = sx - sy;
      3'd2: r = (sx * sy) >>> 8;
      3'd3: begin
        if (sy == 0) r = (sx >= 0) ? 32767 : -32768;
        else         r = (sx * 256) / sy;
      end
      3'd4: begin
        e = sy >>> 8;
        if (e < 0) r = 0;
        else begin
          p = 256;
          for (longint i = 0; i < e; i++) begin
            t = 16'((p * sx) >>> 8);
            p = longint'($signed(t));
          end
          r = p;
        end
      end
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [15:0] y);
    int e = int'($signed(y)) >>> 8;
    if (o == 3'd3) return 0;
    if (o == 3'd4 && e > 0) return 1 + e;
    return 1;
  endfunction

  // Issue one operation, scramble inputs after the start edge, poll until done.
  task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] res, output int lat, output logic done_at_start);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
    done_at_start = done;
    lat = 0;
    while (!done && lat < BOUND) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic check_op(input string name, input logic [2:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] exp, input int exp_lat);
    logic [15:0] res;
    int          lat;
    logic        d0;
    run_op(o, x, y, res, lat, d0);
    check({name, "_done_cleared"}, 32'(d0), 32'd0);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_result"}, 32'(res), 32'(exp));
    if (exp_lat == 0) check({name, "_lat_le_max"}, 32'(lat <= LAT_DIV_MAX), 32'd1);
    else              check({name, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [15:0] res, held;
    int          lat;
    logic        d0;
    logic        saw_done;
    logic [2:0]  ro;
    logic [15:0] rx, ry;
    logic [7:0]  ei;

    tbl[0]  = '{3'd0, 16'h0380, 16'h0140, 16'h04C0, 1};
    tbl[1]  = '{3'd0, 16'h7F00, 16'h0100, 16'h8000, 1};
    tbl[2]  = '{3'd1, 16'h0100, 16'h0200, 16'hFF00, 1};
    tbl[3]  = '{3'd2, 16'h0280, 16'hFE80, 16'hFC40, 1};
    tbl[4]  = '{3'd3, 16'h0700, 16'h0200, 16'h0380, 0};
    tbl[5]  = '{3'd3, 16'hF900, 16'h0200, 16'hFC80, 0};
    tbl[6]  = '{3'd3, 16'h0100, 16'h0000, 16'h7FFF, 0};
    tbl[7]  = '{3'd3, 16'hFF00, 16'h0000, 16'h8000, 0};
    tbl[8]  = '{3'd4, 16'h0180, 16'h0300, 16'h0360, 4};
    tbl[9]  = '{3'd4, 16'h0180, 16'h0000, 16'h0100, 1};
    tbl[10] = '{3'd4, 16'h0180, 16'hFF00, 16'h0000, 1};
    tbl[11] = '{3'd5, 16'h1234, 16'h5678, 16'h0000, 1};

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

    // done and result hold while idle
    run_op(3'd0, 16'h0380, 16'h0140, res, lat, d0);
    held = result;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_done", 32'(done), 32'd1);
      check("hold_result", 32'(result), 32'(held));
    end

    // caller-style: poll two cycles after start, then feed result into DIV
    @(negedge clk); op = 3'd1; a = 16'h0000; b = 16'h0100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("poll_sub_done", 32'(done), 32'd1);
    check("poll_sub_result", 32'(result), 32'h0000FF00);
    held = result;
    check_op("caller_div", 3'd3, held, 16'h1400, ref_model(3'd3, held, 16'h1400), 0);
    check("caller_div_const", 32'(result), 32'h0000FFF4);

    // start pulsed mid-DIV is ignored
    @(negedge clk); op = 3'd3; a = 16'h0700; b = 16'h0200; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    op = 3'd0; a = 16'h0001; b = 16'h0001; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (!done && lat < BOUND) begin @(negedge clk); lat++; end
    check("middiv_done", 32'(done), 32'd1);
    check("middiv_result", 32'(result), 32'h00000380);
    check("middiv_lat", 32'(lat + 6 <= LAT_DIV_MAX + 1), 32'd1);

    // reset during DIV aborts with no later done
    @(negedge clk); op = 3'd3; a = 16'h0700; b = 16'h0200; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_div_done", 32'(done), 32'd0);
    check("rst_div_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("rst_div_no_done", 32'(saw_done), 32'd0);

    // randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (ro == 3'd4) begin
        ei = 8'($urandom_range(0, 9)) - 8'd2;
        ry = {ei, 8'($urandom)};
      end
      if (i % 10 == 0) ry = '0;
      check_op($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry, ref_model(ro, rx, ry), ref_lat(ro, ry));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
